interboard_transmit: RTL

Sending end of the inter-board link. It accepts one game message from the upper layer as a single-cycle command and serializes it as six 6-bit fields over a Request/Ack handshake, in this order: msg_type, block_x, block_y, card, sel_len, move_dir. It can also drive the all-ones remote-reset pattern that the receiving board decodes as interboard_rst. It sits between the local game controller and the board-to-board connector pins.

---
 rtl/interboard_transmit.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/interboard_transmit.sv
// Sending end of the inter-board link: serializes one game message as six
// 6-bit fields over a Request/Ack handshake, or drives the all-ones
// remote-reset pattern on request.
module interboard_transmit #(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned RST_HOLD   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_en,
  input  logic [3:0] msg_type,
  input  logic [4:0] block_x,
  input  logic [2:0] block_y,
  input  logic [5:0] card,
  input  logic [2:0] sel_len,
  input  logic       move_dir,
  input  logic       rst_req,
  input  logic       Ack,
  output logic       Request,
  output logic [5:0] interboard_data,
  output logic       busy,
  output logic       send_done
);

  localparam int unsigned FIELD_W    = 6;
  localparam int unsigned NUM_FIELDS = 6;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned CNT_MAX    = (RST_HOLD > GAP_CYCLES) ? RST_HOLD : GAP_CYCLES;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
  localparam logic [FIELD_W-1:0] RST_PATTERN = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_REQ,
    S_WAIT_LOW,
    S_GAP,
    S_DONE,
    S_RST_OUT
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FIELD_W-1:0] fields_q [NUM_FIELDS];
  logic [FIELD_W-1:0] fields_d [NUM_FIELDS];
  logic               ack_meta, ack_s;
  logic               request_d, busy_d, send_done_d;
  logic [FIELD_W-1:0] data_d;

  // Two-flop synchronizer for the asynchronous Ack from the other board
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= Ack;
      ack_s    <= ack_meta;
    end
  end

  // Next state, field capture, counters and the next value of every output
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    fields_d = fields_q;

    case (state_q)
      S_IDLE: begin
        if (send_en) begin
          fields_d[0] = FIELD_W'(msg_type);
          fields_d[1] = FIELD_W'(block_x);
          fields_d[2] = FIELD_W'(block_y);
          fields_d[3] = card;
          fields_d[4] = FIELD_W'(sel_len);
          fields_d[5] = FIELD_W'(move_dir);
          idx_d       = '0;
          state_d     = S_SETUP;
        end
      end
      S_SETUP: state_d = S_REQ;
      S_REQ: begin
        if (ack_s) state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!ack_s) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          if (idx_q == IDX_W'(NUM_FIELDS - 1)) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_SETUP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      S_RST_OUT: begin
        // Leave only once the request is gone and the minimum hold has elapsed
        if (!rst_req && (cnt_q >= CNT_W'(RST_HOLD - 1))) begin
          state_d = S_IDLE;
        end else if (cnt_q < CNT_W'(RST_HOLD - 1)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Remote reset wins over everything, including a same-cycle send_en
    if (rst_req && (state_q != S_RST_OUT)) begin
      state_d  = S_RST_OUT;
      cnt_d    = '0;
      idx_d    = idx_q;
      fields_d = fields_q;
    end

    request_d   = (state_d == S_REQ) || (state_d == S_RST_OUT);
    busy_d      = (state_d != S_IDLE);
    send_done_d = (state_d == S_DONE);
    case (state_d)
      S_SETUP:                   data_d = fields_d[idx_d];
      S_REQ, S_WAIT_LOW, S_GAP:  data_d = interboard_data;
      S_RST_OUT:                 data_d = RST_PATTERN;
      default:                   data_d = '0;
    endcase
  end

  // State, field storage and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      cnt_q           <= '0;
      for (int i = 0; i < NUM_FIELDS; i++) fields_q[i] <= '0;
      Request         <= 1'b0;
      interboard_data <= '0;
      busy            <= 1'b0;
      send_done       <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      cnt_q           <= cnt_d;
      fields_q        <= fields_d;
      Request         <= request_d;
      interboard_data <= data_d;
      busy            <= busy_d;
      send_done       <= send_done_d;
    end
  end

endmodule
